// File: rtl/hs_rx_pkg.sv
// Shared definitions for the handshake frame receiver: FSM state encodings and
// field offsets inside a W+2 bit link word.
package hs_rx_pkg;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t ST_IDLE      = 3'd0;
    localparam rx_state_t ST_HDR_ACK   = 3'd1;
    localparam rx_state_t ST_DWAIT     = 3'd2;
    localparam rx_state_t ST_DACK      = 3'd3;
    localparam rx_state_t ST_PUBLISH   = 3'd4;
    localparam rx_state_t ST_ABORT_ACK = 3'd5;

    function automatic int unsigned last_bit(input int unsigned w);
        return w;
    endfunction

    function automatic int unsigned par_bit(input int unsigned w);
        return w + 1;
    endfunction

endpackage

// File: rtl/hs_req_sync.sv
// Multi-flop synchronizer for a single asynchronous handshake line.
module hs_req_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/hs_frame_receiver.sv
// Four-phase handshake frame receiver: header carries the channel tag, data chunks follow.
// Optional mid-frame idle timeout enabled by defining RX_TIMEOUT_EN.
module hs_frame_receiver
    import hs_rx_pkg::*;
#(
    parameter int unsigned N           = 1500,
    parameter int unsigned W           = 4,
    parameter int unsigned CH_BITS     = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 1024,
    localparam int unsigned CHUNKS     = (N + W - 1) / W,
    localparam int unsigned PW         = $clog2(CHUNKS + 1)
) (
    input  logic               clk_receiver,
    input  logic               rst,
    input  logic               wire_req,
    input  logic [W+1:0]       wire_data_deliver,
    output logic               reg_ack,
    output logic               reg_valid,
    output logic [N-1:0]       wire_data_out,
    output logic [CH_BITS-1:0] reg_channel,
    output logic [PW-1:0]      reg_frame_len,
    output logic [7:0]         reg_err_count,
    output logic               reg_parity_err
);

    localparam int unsigned LAST = last_bit(W);
    localparam int unsigned PAR  = par_bit(W);

    logic         req_s;
    logic [W-1:0] payload;
    logic         last_in;
    logic         par_ok;
    logic         tmo_hit;
    logic         err_inc;

    rx_state_t             state_q, state_d;
    logic                  ack_q, ack_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  armed_q, armed_d;
    logic                  last_q, last_d;
    logic [N-1:0]          data_q, data_d;
    logic [CH_BITS-1:0]    chan_q, chan_d;
    logic [CH_BITS-1:0]    tag_q, tag_d;
    logic [PW-1:0]         len_q, len_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [7:0]            err_q, err_d;
    logic [CHUNKS*W-1:0]   buf_q, buf_d;

    hs_req_sync #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk_i (clk_receiver),
        .rst_i (rst),
        .d_i   (wire_req),
        .q_o   (req_s)
    );

    assign payload = wire_data_deliver[W-1:0];
    assign last_in = wire_data_deliver[LAST];
    assign par_ok  = ^{wire_data_deliver[PAR], wire_data_deliver[W:0]};

`ifdef RX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;

    always_ff @(posedge clk_receiver) begin
        if (rst || state_q != ST_DWAIT || req_s || tmo_hit) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    assign tmo_hit = (state_q == ST_DWAIT) && !req_s && (tmo_q == TW'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign tmo_hit        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        valid_d = 1'b0;
        perr_d  = 1'b0;
        armed_d = armed_q;
        last_d  = last_q;
        data_d  = data_q;
        chan_d  = chan_q;
        tag_d   = tag_q;
        len_d   = len_q;
        ptr_d   = ptr_q;
        buf_d   = buf_q;
        err_inc = 1'b0;

        // One parity error report per req high interval; re-armed once req drops.
        if (!req_s) begin
            armed_d = 1'b1;
        end
        if ((state_q == ST_IDLE || state_q == ST_DWAIT) && req_s && !par_ok && armed_q) begin
            perr_d  = 1'b1;
            err_inc = 1'b1;
            armed_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_s && par_ok) begin
                    ack_d = 1'b1;
                    tag_d = payload[CH_BITS-1:0];
                    buf_d = '0;
                    ptr_d = '0;
                    if (last_in) begin
                        err_inc = 1'b1;
                        state_d = ST_ABORT_ACK;
                    end else begin
                        state_d = ST_HDR_ACK;
                    end
                end
            end
            ST_HDR_ACK: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = ST_DWAIT;
                end
            end
            ST_DWAIT: begin
                if (req_s && par_ok) begin
                    ack_d = 1'b1;
                    if (ptr_q == PW'(CHUNKS)) begin
                        err_inc = 1'b1;
                        state_d = ST_ABORT_ACK;
                    end else begin
                        for (int k = 0; k < CHUNKS; k++) begin
                            if (ptr_q == PW'(k)) begin
                                buf_d[k*W +: W] = payload;
                            end
                        end
                        ptr_d   = ptr_q + 1'b1;
                        last_d  = last_in;
                        state_d = ST_DACK;
                    end
                end else if (tmo_hit) begin
                    err_inc = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DACK: begin
                if (!req_s) begin
                    ack_d = 1'b0;
                    if (last_q || ptr_q == PW'(CHUNKS)) begin
                        state_d = ST_PUBLISH;
                    end else begin
                        state_d = ST_DWAIT;
                    end
                end
            end
            ST_PUBLISH: begin
                data_d  = buf_q[N-1:0];
                chan_d  = tag_q;
                len_d   = ptr_q;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ABORT_ACK: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk_receiver) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            armed_q <= 1'b1;
            last_q  <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
            tag_q   <= '0;
            len_q   <= '0;
            ptr_q   <= '0;
            err_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            armed_q <= armed_d;
            last_q  <= last_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            tag_q   <= tag_d;
            len_q   <= len_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            buf_q   <= buf_d;
        end
    end

    assign reg_ack        = ack_q;
    assign reg_valid      = valid_q;
    assign wire_data_out  = data_q;
    assign reg_channel    = chan_q;
    assign reg_frame_len  = len_q;
    assign reg_err_count  = err_q;
    assign reg_parity_err = perr_q;

endmodule

// File: doc/hs_frame_receiver.md
Name: hs_frame_receiver

Overview:
- Parametrised four-phase handshake frame receiver. Successor to the fixed 4-bit/1500-bit receiver.
- Generalised in chunk width (W), frame length (N) and channel tag. Adds a req synchronizer, parity-error and overflow accounting, short-frame padding, and a frame-length report.
- Sits on the receiving side of the inter-board data link, after the pins. Hands completed frames to the game-state decode logic.

Parameters:
N, 1500, frame payload bits.
W, 4, payload bits per chunk.
CH_BITS, 2, channel tag bits carried in the header (CH_BITS<=W).
SYNC_STAGES, 2, flops on wire_req (legal 1..3).
TIMEOUT, 1024, idle cycles before a mid-frame abort (RX_TIMEOUT_EN only).
Derived: CHUNKS=ceil(N/W); PW=$clog2(CHUNKS+1).

Ports:
clk_receiver  in  1  receiver clock
rst  in  1  synchronous active-high reset
wire_req  in  1  sender request (asynchronous to clk_receiver)
wire_data_deliver  in  W+2  [W-1:0] payload, [W] last flag, [W+1] parity bit
reg_ack  out  1  acknowledge to sender
reg_valid  out  1  one-cycle pulse: frame published
wire_data_out  out  N  last complete frame; chunk k occupies bits [kW+W-1:kW]
reg_channel  out  CH_BITS  channel tag of the published frame
reg_frame_len  out  PW  chunks received in the published frame
reg_err_count  out  8  saturating count of protocol errors
reg_parity_err  out  1  one-cycle pulse per rejected request

Behaviour:
- Reset: all outputs 0, sync flops 0, FSM in IDLE. Reset mid-frame discards the partial frame; no valid pulse is produced.
- req_s = wire_req after SYNC_STAGES flops. Data is sampled only when req_s=1; four-phase signalling guarantees it is stable.
- Parity OK ⇔ XOR of all W+2 bits of wire_data_deliver = 1 (odd parity).
- States:
  - IDLE: on req_s=1 and parity OK, latch the header tag (payload[CH_BITS-1:0]) into a staging register, clear the chunk buffer and pointer, set ack=1, go to HDR_ACK.
  - Header with last flag set: protocol error (err_count+1), ack still given, go to ABORT_ACK.
  - HDR_ACK: hold ack=1 until req_s=0, then ack=0, go to DWAIT.
  - DWAIT: on req_s=1 and parity OK:
    - If ptr<CHUNKS: store the payload at chunk ptr, ptr+1, ack=1, go to DACK.
    - If ptr==CHUNKS (overflow): err_count+1, ack=1, go to ABORT_ACK.
  - DACK: on req_s=0, ack=0. If the stored chunk had last=1 or ptr==CHUNKS, go to PUBLISH; otherwise go to DWAIT.
  - PUBLISH (one cycle):
    - wire_data_out <= buffer. Unreceived chunks are 0; bits above N in the final chunk are dropped.
    - reg_channel <= staging tag; reg_frame_len <= ptr; reg_valid=1.
    - Go to IDLE.
  - ABORT_ACK: on req_s=0, ack=0, go to IDLE. Outputs unchanged.
- Parity failure in any wait state: no ack, no store, state unchanged, and the receiver re-samples every cycle. reg_parity_err pulses and err_count increments once per req_s high interval (armed by req_s falling).
- ack latency: ack rises on the SYNC_STAGES+1-th rising edge after wire_req rises. ack falls SYNC_STAGES+1 edges after wire_req falls.
- Frame reaching CHUNKS without a last flag: published normally (last is implied).
- wire_data_out, reg_channel and reg_frame_len hold their values between valid pulses.
- err_count saturates at 255.

Optional Feature:
RX_TIMEOUT_EN:
- Defined: a counter runs while in DWAIT with req_s=0. On reaching TIMEOUT: err_count+1, go to IDLE, partial frame discarded, no valid pulse. The counter clears on any req_s=1.
- Undefined: no counter; the receiver waits indefinitely in DWAIT.

Decomposition:
- Package hs_rx_pkg: FSM state enum (IDLE, HDR_ACK, DWAIT, DACK, PUBLISH, ABORT_ACK) and field-offset constants (PAR_BIT=W+1, LAST_BIT=W), as functions of W.
- Sub-module hs_req_sync: SYNC_STAGES-deep synchronizer with synchronous reset. Reused by the future transmitter's ack path.

Test Plan:
All scenarios use N=12, W=4, CHUNKS=3, SYNC_STAGES=2.
1. Header tag=2, then chunks 0xA, 0x5, 0x3(last), all with good parity → wire_data_out=0x35A, reg_channel=2, reg_frame_len=3, one valid pulse; ack rises 3 edges after each req rise.
2. Header, then chunk 0x7 with last set → data_out=0x007, frame_len=1, valid pulse.
3. Bad parity on chunk 1, held 10 cycles, then corrected → ack stays 0 until the correction, parity_err pulses once, err_count=1, final data correct.
4. Header plus 4 chunks with no last flag → frame published after chunk 3. The following header-less chunk is treated as a header, so the test must drive a fresh header.
5. rst asserted mid-frame after chunk 1 → all outputs 0, ack=0 the next cycle; a new full frame then completes correctly.
6. RX_TIMEOUT_EN defined, TIMEOUT=16: stall 16 cycles after chunk 0 → FSM returns to IDLE, err_count=1, no valid pulse.
